debug_trigger_ctrl: RTL and testbench
=====================================

Name: debug_trigger_ctrl

Overview:
- Sequencer that sits in front of the debug trace capture buffer and drives its capture_enable, capture_data and trigger inputs.
- Compares a masked probe bus against a programmable pattern and counts occurrences.
- After the Nth hit, keeps capturing a programmable number of post-trigger samples, then pulses trigger so the buffer dumps over the UART.
- Capture is therefore centred on the event of interest, not on the moment the buffer stops.

Parameters:
DATA_WIDTH, 32, width of probe bus and capture_data
COUNT_WIDTH, 16, width of match-count and post-count registers

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
arm  input  1  pulse: latch config, clear counters, enter ARMED
abort  input  1  pulse: return to IDLE; priority over arm
probe_data  input  DATA_WIDTH  observed value
probe_valid  input  1  probe_data is a sample this cycle
match_value  input  DATA_WIDTH  pattern, latched on arm
match_mask  input  DATA_WIDTH  1 = bit compared, latched on arm
match_count  input  COUNT_WIDTH  hits required; 0 treated as 1; latched on arm
post_count  input  COUNT_WIDTH  valid samples captured after the triggering hit; latched on arm
capture_data  output  DATA_WIDTH  registered copy of probe_data
capture_enable  output  1  registered; write capture_data this cycle
trigger  output  1  registered one-cycle pulse; start dump
armed  output  1  state is ARMED or POST
done  output  1  state is DONE

Behaviour:
- Reset values: state IDLE; capture_enable 0, trigger 0, capture_data 0, armed 0, done 0; hit counter 0, post counter 0.
- All outputs are registered. capture_data/capture_enable lag probe_data/probe_valid by exactly 1 cycle.
- hit = probe_valid && (((probe_data ^ match_value_q) & match_mask_q) == 0). An all-zero mask matches every valid sample.
- IDLE: capture_enable 0. arm -> ARMED.
- ARMED: capture_enable <= probe_valid.
  - On hit, if hits_q == max(match_count_q,1) - 1 -> POST, post_remaining <= post_count_q.
  - Otherwise on hit, hits_q += 1; saturates at all-ones.
  - The triggering sample itself is captured.
- POST:
  - If post_remaining == 0: trigger <= 1, capture_enable <= 0, -> DONE.
  - Else: capture_enable <= probe_valid; decrement post_remaining on each probe_valid.
  - Hits are ignored in POST.
- DONE: capture_enable 0. trigger is high on the first DONE cycle only. Stay in DONE until arm or abort.
- Latency, post_count = 0: hit at cycle t -> captured at t+1 -> trigger high at t+2.
- Latency, general: trigger asserts exactly 1 cycle after the cycle in which the post_count-th post sample was written.
- abort in any state: -> IDLE, counters cleared, capture_enable and trigger forced 0 next cycle.
- abort and arm in the same cycle: abort wins.
- arm while ARMED/POST/DONE: re-latch config, clear counters, -> ARMED. The sample presented on the arm cycle is not captured and not compared (config is not yet latched).
- Config inputs are sampled only on arm. Changes at any other time have no effect.
- probe_valid low: no capture, no counting, no post decrement; state holds.
- Reset mid-POST: immediate return to reset values. No trigger is emitted.

Decomposition:
- Shared package debug_pkg holds the trigger_state_t enum (IDLE, ARMED, POST, DONE). The trace buffer and other debug blocks reuse it.
- One sub-module, debug_pattern_match: combinational masked compare, parameterised by DATA_WIDTH, output hit. Reusable for multi-stage triggers later.
- Counters and the FSM stay in debug_trigger_ctrl.

Test Plan:
- Basic trigger: arm, value 0x0000_00A5, mask 0x0000_00FF, count 1, post 0. Drive valid 0x11, 0x12, 0x1234_56A5 -> capture_enable for all three (1-cycle lag); trigger pulses 1 cycle after the 0x...A5 capture; done=1; later samples not captured.
- Nth occurrence plus post samples: count 3, post 4, with 3 hits interleaved with misses and probe_valid gaps -> trigger only after the 3rd hit plus 4 further valid captures. Exactly 4 capture_enable pulses between the 3rd-hit capture and trigger, and trigger is high for exactly 1 cycle.
- count 0 and mask 0: arm -> first valid sample triggers; count 0 behaves identically to count 1.
- Abort: abort mid-POST with 2 samples remaining -> next cycle capture_enable 0, armed 0; trigger never asserts. Repeat with arm and abort in the same cycle -> ends in IDLE.
- Re-arm: re-arm from DONE with new match_value 0x55, while changing the config inputs after the arm cycle -> only the latched 0x55 triggers. Hit counter starts from 0.
- Async reset: assert reset in POST between clock edges -> all outputs 0 immediately, state IDLE. No trigger after release until a new arm.

Source files
------------

// File: rtl/debug_pkg.sv
// Shared debug-subsystem types: trigger sequencer state, reused by the trace buffer.
// Pure type package; no logic, no latency.
package debug_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARMED = 2'd1,
      POST  = 2'd2,
      DONE  = 2'd3
   } trigger_state_t;

endpackage

// File: rtl/debug_pattern_match.sv
// Masked pattern compare on a probe sample; hit only for valid samples.
// Combinational, zero latency; no backpressure.
module debug_pattern_match #(
   parameter int DATA_WIDTH = 32
) (
   input  logic [DATA_WIDTH-1:0] data,
   input  logic                  valid,
   input  logic [DATA_WIDTH-1:0] value,
   input  logic [DATA_WIDTH-1:0] mask,
   output logic                  hit
);

   // Mask bit 1 means "compare this bit"; an all-zero mask matches any valid sample.
   assign hit = valid && (((data ^ value) & mask) == '0);

endmodule

// File: rtl/debug_trigger_ctrl.sv
// Trace-capture sequencer: counts pattern hits, captures post-trigger samples, then pulses trigger.
// All outputs registered, capture lags probe by 1 cycle; no backpressure, the buffer must accept every sample.
module debug_trigger_ctrl
   import debug_pkg::*;
#(
   parameter int DATA_WIDTH  = 32,
   parameter int COUNT_WIDTH = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   arm,
   input  logic                   abort,
   input  logic [DATA_WIDTH-1:0]  probe_data,
   input  logic                   probe_valid,
   input  logic [DATA_WIDTH-1:0]  match_value,
   input  logic [DATA_WIDTH-1:0]  match_mask,
   input  logic [COUNT_WIDTH-1:0] match_count,
   input  logic [COUNT_WIDTH-1:0] post_count,
   output logic [DATA_WIDTH-1:0]  capture_data,
   output logic                   capture_enable,
   output logic                   trigger,
   output logic                   armed,
   output logic                   done
);

   localparam logic [COUNT_WIDTH-1:0] CNT_ONE = COUNT_WIDTH'(1);

   trigger_state_t state_q, state_d;

   logic [DATA_WIDTH-1:0]  match_value_q, match_value_d;
   logic [DATA_WIDTH-1:0]  match_mask_q, match_mask_d;
   logic [COUNT_WIDTH-1:0] match_count_q, match_count_d;
   logic [COUNT_WIDTH-1:0] post_count_q, post_count_d;
   logic [COUNT_WIDTH-1:0] hits_q, hits_d;
   logic [COUNT_WIDTH-1:0] post_remaining_q, post_remaining_d;
   logic [COUNT_WIDTH-1:0] hit_target;
   logic                   capture_enable_d;
   logic                   trigger_d;
   logic                   hit;

   debug_pattern_match #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_match (
      .data  (probe_data),
      .valid (probe_valid),
      .value (match_value_q),
      .mask  (match_mask_q),
      .hit   (hit)
   );

   // A programmed count of 0 behaves as 1: the first hit triggers.
   assign hit_target = (match_count_q == '0) ? '0 : (match_count_q - CNT_ONE);

   always_comb begin
      state_d          = state_q;
      match_value_d    = match_value_q;
      match_mask_d     = match_mask_q;
      match_count_d    = match_count_q;
      post_count_d     = post_count_q;
      hits_d           = hits_q;
      post_remaining_d = post_remaining_q;
      capture_enable_d = 1'b0;
      trigger_d        = 1'b0;

      if (abort) begin
         state_d          = IDLE;
         hits_d           = '0;
         post_remaining_d = '0;
      end else if (arm) begin
         // The arm-cycle sample is neither compared nor captured: config is latched only now.
         state_d          = ARMED;
         match_value_d    = match_value;
         match_mask_d     = match_mask;
         match_count_d    = match_count;
         post_count_d     = post_count;
         hits_d           = '0;
         post_remaining_d = '0;
      end else begin
         case (state_q)
            IDLE: begin
            end
            ARMED: begin
               capture_enable_d = probe_valid;
               if (hit) begin
                  if (hits_q == hit_target) begin
                     state_d          = POST;
                     post_remaining_d = post_count_q;
                  end else if (hits_q != '1) begin
                     hits_d = hits_q + CNT_ONE;
                  end
               end
            end
            POST: begin
               if (post_remaining_q == '0) begin
                  trigger_d = 1'b1;
                  state_d   = DONE;
               end else begin
                  capture_enable_d = probe_valid;
                  if (probe_valid) begin
                     post_remaining_d = post_remaining_q - CNT_ONE;
                  end
               end
            end
            DONE: begin
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q          <= IDLE;
         match_value_q    <= '0;
         match_mask_q     <= '0;
         match_count_q    <= '0;
         post_count_q     <= '0;
         hits_q           <= '0;
         post_remaining_q <= '0;
         capture_data     <= '0;
         capture_enable   <= 1'b0;
         trigger          <= 1'b0;
         armed            <= 1'b0;
         done             <= 1'b0;
      end else begin
         state_q          <= state_d;
         match_value_q    <= match_value_d;
         match_mask_q     <= match_mask_d;
         match_count_q    <= match_count_d;
         post_count_q     <= post_count_d;
         hits_q           <= hits_d;
         post_remaining_q <= post_remaining_d;
         capture_data     <= probe_data;
         capture_enable   <= capture_enable_d;
         trigger          <= trigger_d;
         armed            <= (state_d == ARMED) || (state_d == POST);
         done             <= (state_d == DONE);
      end
   end

endmodule

// File: tb/tb_debug_trigger_ctrl.sv
// Bench for debug_trigger_ctrl: directed scenarios plus random sequences against an event-level model.
module tb_debug_trigger_ctrl;

   localparam int DW     = 32;
   localparam int CW     = 16;
   localparam int MAXLEN = 64;

   logic          clk = 1'b0;
   logic          reset;
   logic          arm, abort, probe_valid;
   logic [DW-1:0] probe_data, match_value, match_mask;
   logic [CW-1:0] match_count, post_count;
   logic [DW-1:0] capture_data;
   logic          capture_enable, trigger, armed, done;

   int n_assert = 0;
   int n_fail   = 0;

   logic          sv_v [MAXLEN];
   logic [DW-1:0] sv_d [MAXLEN];
   logic [DW-1:0] cfg_val, cfg_mask;
   logic [CW-1:0] cfg_cnt, cfg_post;

   always #5 clk = ~clk;

   debug_trigger_ctrl #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW)) dut (
      .clk            (clk),
      .reset          (reset),
      .arm            (arm),
      .abort          (abort),
      .probe_data     (probe_data),
      .probe_valid    (probe_valid),
      .match_value    (match_value),
      .match_mask     (match_mask),
      .match_count    (match_count),
      .post_count     (post_count),
      .capture_data   (capture_data),
      .capture_enable (capture_enable),
      .trigger        (trigger),
      .armed          (armed),
      .done           (done)
   );

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
      end
   endtask

   function automatic bit is_hit(input logic [DW-1:0] d);
      return ((d ^ cfg_val) & cfg_mask) == '0;
   endfunction

   task automatic set_cfg(input logic [DW-1:0] v, input logic [DW-1:0] m,
                          input logic [CW-1:0] c, input logic [CW-1:0] p);
      cfg_val = v; cfg_mask = m; cfg_cnt = c; cfg_post = p;
   endtask

   task automatic clear_seq(input logic valid_fill);
      for (int i = 0; i < MAXLEN; i++) begin
         sv_v[i] = valid_fill;
         sv_d[i] = '0;
      end
   endtask

   task automatic check_idle(input string tag);
      chk({tag, "_cap"},   DW'(capture_enable), '0);
      chk({tag, "_trig"},  DW'(trigger),        '0);
      chk({tag, "_armed"}, DW'(armed),          '0);
      chk({tag, "_done"},  DW'(done),           '0);
   endtask

   // Arm at cycle 0 with cfg_*, then play sv_v/sv_d. Expected outputs come from locating
   // the Nth valid hit and the post_count-th valid sample after it.
   task automatic run_seq(input int len, input int abort_at);
      int thr, hits, hit_n, last_p, pc, trig_edge, caps_post, trig_seen;
      logic e_cap, e_trig, e_armed, e_done, active, killed;
      thr    = (cfg_cnt == '0) ? 1 : int'(cfg_cnt);
      hits   = 0; hit_n = -1; last_p = -1; pc = 0;
      for (int i = 1; i < len; i++) begin
         if (hit_n < 0) begin
            if (sv_v[i] && is_hit(sv_d[i])) begin
               hits++;
               if (hits == thr) begin
                  hit_n = i;
                  if (cfg_post == '0) last_p = i;
               end
            end
         end else if (last_p < 0 && sv_v[i]) begin
            pc++;
            if (pc == int'(cfg_post)) last_p = i;
         end
      end
      trig_edge = (last_p >= 0) ? last_p + 1 : -1;
      caps_post = 0;
      trig_seen = 0;
      for (int i = 0; i < len; i++) begin
         arm         = (i == 0);
         abort       = (i == abort_at);
         probe_valid = sv_v[i];
         probe_data  = sv_d[i];
         if (i == 0) begin
            match_value = cfg_val; match_mask = cfg_mask;
            match_count = cfg_cnt; post_count = cfg_post;
         end else begin
            match_value = $urandom; match_mask = $urandom;
            match_count = CW'($urandom); post_count = CW'($urandom);
         end
         @(posedge clk);
         #1;
         killed  = (abort_at >= 0) && (i >= abort_at);
         active  = (i >= 1) && ((last_p < 0) || (i <= last_p));
         e_cap   = !killed && active && sv_v[i];
         e_trig  = !killed && (i == trig_edge);
         e_armed = !killed && ((i == 0) || active);
         e_done  = !killed && !((i == 0) || active);
         chk($sformatf("cap_en@%0d", i), DW'(capture_enable), DW'(e_cap));
         chk($sformatf("trigger@%0d", i), DW'(trigger), DW'(e_trig));
         chk($sformatf("armed@%0d", i), DW'(armed), DW'(e_armed));
         chk($sformatf("done@%0d", i), DW'(done), DW'(e_done));
         if (e_cap) chk($sformatf("cap_data@%0d", i), capture_data, sv_d[i]);
         if (hit_n >= 0 && i > hit_n && (trig_edge < 0 || i < trig_edge) && capture_enable === 1'b1)
            caps_post++;
         if (trigger === 1'b1) trig_seen++;
      end
      arm = 1'b0; abort = 1'b0; probe_valid = 1'b0;
      if (abort_at < 0 && trig_edge >= 0 && trig_edge < len) begin
         chk("post_caps", DW'(caps_post), DW'(cfg_post));
         chk("trig_pulses", DW'(trig_seen), DW'(1));
      end
   endtask

   initial begin
      reset = 1'b1; arm = 1'b0; abort = 1'b0; probe_valid = 1'b0; probe_data = '0;
      match_value = '0; match_mask = '0; match_count = '0; post_count = '0;
      #1;
      check_idle("reset");
      chk("reset_data", capture_data, '0);
      #21 reset = 1'b0;

      // Basic: third sample hits, later hits not captured
      set_cfg(32'h0000_00A5, 32'h0000_00FF, 16'd1, 16'd0);
      clear_seq(1'b1);
      sv_v[0] = 1'b0;
      sv_d[1] = 32'h11; sv_d[2] = 32'h12; sv_d[3] = 32'h1234_56A5;
      for (int i = 4; i < 10; i++) sv_d[i] = 32'hA5;
      run_seq(10, -1);

      // Third hit plus four post samples, with misses and valid gaps
      set_cfg(32'h0000_00A5, 32'h0000_00FF, 16'd3, 16'd4);
      clear_seq(1'b0);
      sv_v[0] = 1; sv_d[0] = 32'hA5;
      sv_v[1] = 1; sv_d[1] = 32'hA5;
      sv_d[2] = 32'hA5;
      sv_v[3] = 1; sv_d[3] = 32'h100;
      sv_v[4] = 1; sv_d[4] = 32'h7700_00A5;
      sv_v[5] = 1; sv_d[5] = 32'h1FF;
      sv_v[7] = 1; sv_d[7] = 32'hA5A5;
      sv_v[8] = 1; sv_d[8] = 32'h3;
      sv_v[10] = 1; sv_d[10] = 32'hA5;
      sv_v[11] = 1; sv_d[11] = 32'h44;
      sv_v[13] = 1; sv_d[13] = 32'h55;
      for (int i = 14; i < 24; i++) begin sv_v[i] = 1; sv_d[i] = 32'hA5; end
      run_seq(24, -1);

      // count 0 and count 1 with an all-zero mask: first valid sample after arm triggers
      for (int k = 0; k < 2; k++) begin
         set_cfg($urandom, '0, CW'(k), 16'd0);
         clear_seq(1'b0);
         sv_v[0] = 1;
         for (int i = 0; i < 10; i++) sv_d[i] = $urandom;
         sv_v[3] = 1; sv_v[5] = 1;
         run_seq(10, -1);
      end

      // Abort in POST with two post samples still outstanding
      set_cfg(32'hA5, 32'hFF, 16'd1, 16'd5);
      clear_seq(1'b1);
      sv_d[1] = 32'hA5;
      for (int i = 8; i < 14; i++) sv_d[i] = 32'hA5;
      run_seq(14, 5);

      // Arm and abort together while in POST: abort wins
      run_seq(6, -1);
      run_seq(8, 0);

      // Re-arm from DONE and from ARMED with a partial hit count
      set_cfg(32'hA5, 32'hFF, 16'd1, 16'd0);
      clear_seq(1'b1);
      sv_d[2] = 32'hA5;
      run_seq(6, -1);
      set_cfg(32'h55, 32'hFF, 16'd2, 16'd1);
      clear_seq(1'b1);
      sv_d[1] = 32'h55;
      run_seq(5, -1);
      clear_seq(1'b1);
      sv_d[1] = 32'hA5; sv_d[2] = 32'h55; sv_d[3] = 32'hA5; sv_d[4] = 32'h11;
      sv_d[5] = 32'hAB55; sv_d[6] = 32'hA5; sv_d[7] = 32'h55;
      run_seq(12, -1);

      // Asynchronous reset between edges while in POST
      set_cfg(32'hA5, 32'hFF, 16'd1, 16'd8);
      clear_seq(1'b1);
      sv_d[1] = 32'hA5;
      run_seq(4, -1);
      #3 reset = 1'b1;
      #1;
      check_idle("async_rst");
      chk("async_rst_data", capture_data, '0);
      @(posedge clk);
      #1;
      check_idle("rst_hold");
      #2 reset = 1'b0;
      for (int i = 0; i < 12; i++) begin
         probe_valid = 1'b1;
         probe_data  = 32'hA5;
         @(posedge clk);
         #1;
         check_idle($sformatf("post_rst%0d", i));
      end
      probe_valid = 1'b0;

      // Random configurations and traffic
      for (int n = 0; n < 40; n++) begin
         int len, vpct, hpct, ab;
         logic [DW-1:0] m;
         case ($urandom_range(3))
            0: m = '0;
            1: m = 32'h0000_00FF;
            2: m = $urandom;
            default: m = '1;
         endcase
         set_cfg($urandom, m, CW'($urandom_range(4)), CW'($urandom_range(6)));
         len  = 48;
         vpct = 40 + $urandom_range(50);
         hpct = 10 + $urandom_range(30);
         for (int i = 0; i < len; i++) begin
            sv_v[i] = ($urandom_range(99) < vpct);
            if ($urandom_range(99) < hpct) sv_d[i] = (cfg_val & cfg_mask) | ($urandom & ~cfg_mask);
            else sv_d[i] = $urandom;
         end
         ab = ($urandom_range(4) == 0) ? $urandom_range(len - 1) : -1;
         run_seq(len, ab);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
